bus85_slave: RTL

- 8085-compatible bus responder that sits on the multiplexed AD bus opposite the CPU control unit, on the peripheral/memory side.
- Demultiplexes the address with ALE and decodes IO/M_, S1, S0, RD_, WR_ and INTA_.
- Drives READY to insert wait states.
- Turns each selected bus cycle into a single-request local read/write handshake toward a memory or I/O device.

---
 rtl/bus85_slave.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/bus85_slave.sv
`timescale 1ns/1ps
// bus85_slave -- 8085 bus responder on the peripheral/memory side.
//
// Demultiplexes the AD bus with ALE, decodes IO/M_ + S1/S0 against a memory
// window, an I/O port window and (optionally) interrupt acknowledge, holds
// READY low while a single-request local handshake runs, and drives read
// data back onto AD while the CPU strobe is low.
//
// Ports:
//   clk_, rst_          clock; asynchronous active-high reset
//   ale, iom_, s1, s0   CPU address-latch strobe and bus-cycle status
//   rd_, wr_, inta_     CPU strobes, active low
//   a_hi, ad_i          A15..A8 and AD7..AD0 as seen on the bus
//   ad_o, ad_oe         read data / opcode and its bus drive enable
//   ready, ready_oe     READY to CPU and ownership of the READY line
//   loc_*               local request side: address, I/O flag, one-cycle
//                       rd/wr pulses, write data, read data + ack
//   err                 one-cycle pulse when the local ack timed out
module bus85_slave #(
    parameter logic [15:0] MEM_BASE = 16'h0000,
    parameter logic [15:0] MEM_MASK = 16'hF000,
    parameter logic [7:0]  IO_BASE  = 8'h00,
    parameter logic [7:0]  IO_MASK  = 8'hF0,
    parameter int unsigned WAITS    = 0,
    parameter int unsigned TIMEOUT  = 15,
    parameter bit          INTA_EN  = 1'b0,
    parameter logic [7:0]  INTA_OPC = 8'hFF
) (
    input  logic        clk_,
    input  logic        rst_,
    input  logic        ale,
    input  logic        iom_,
    input  logic        s1,
    input  logic        s0,
    input  logic        rd_,
    input  logic        wr_,
    input  logic        inta_,
    input  logic [7:0]  a_hi,
    input  logic [7:0]  ad_i,
    output logic [7:0]  ad_o,
    output logic        ad_oe,
    output logic        ready,
    output logic        ready_oe,
    output logic [15:0] loc_addr,
    output logic        loc_io,
    output logic        loc_rd,
    output logic        loc_wr,
    output logic [7:0]  loc_wdata,
    input  logic [7:0]  loc_rdata,
    input  logic        loc_ack,
    output logic        err
);

    typedef enum logic [2:0] {S_IDLE, S_LATCH, S_REQ, S_WAIT, S_DONE} state_t;

    state_t      state_q;
    logic [7:0]  ad_q;
    logic        ready_q, ready_oe_q;
    logic [15:0] addr_q;
    logic        io_q, rd_q, wr_q, err_q;
    logic [7:0]  wdata_q;
    logic        inta_q;     // current cycle decoded as interrupt acknowledge
    logic        cyc_wr_q;   // current cycle is a write (no AD drive)
    logic        acked_q;
    logic [3:0]  wcnt_q;
    logic [7:0]  tcnt_q;

    // Address decode, evaluated whenever ALE is sampled.
    logic        io_type_d, mem_hit_d, io_hit_d, inta_hit_d, hit_d;
    logic [15:0] addr_d;
    logic        strobe;
    logic        ack_now;

    always_comb begin
        io_type_d  = iom_ & (s1 ^ s0);
        mem_hit_d  = ~iom_ & (s1 | s0) & (MEM_MASK != 16'h0000) &
                     ((({a_hi, ad_i}) & MEM_MASK) == (MEM_BASE & MEM_MASK));
        io_hit_d   = io_type_d & (IO_MASK != 8'h00) &
                     ((ad_i & IO_MASK) == (IO_BASE & IO_MASK));
        inta_hit_d = iom_ & s1 & s0 & INTA_EN;
        hit_d      = mem_hit_d | io_hit_d | inta_hit_d;
        // I/O ports only carry 8 address bits; A15..A8 is a mirror of them.
        addr_d     = io_type_d ? {8'h00, ad_i} : {a_hi, ad_i};
    end

    assign strobe  = ~rd_ | ~wr_ | ~inta_;
    // INTA has nothing to acknowledge locally; it completes on the wait count.
    assign ack_now = acked_q | loc_ack | inta_q;

    always_ff @(posedge clk_ or posedge rst_) begin
        if (rst_) begin
            state_q    <= S_IDLE;
            ad_q       <= 8'h00;
            ready_q    <= 1'b1;
            ready_oe_q <= 1'b0;
            addr_q     <= 16'h0000;
            io_q       <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            wdata_q    <= 8'h00;
            err_q      <= 1'b0;
            inta_q     <= 1'b0;
            cyc_wr_q   <= 1'b0;
            acked_q    <= 1'b0;
            wcnt_q     <= 4'd0;
            tcnt_q     <= 8'd0;
        end else begin
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (ale) begin
                        addr_q <= addr_d;
                        io_q   <= io_type_d;
                        inta_q <= inta_hit_d;
                        if (hit_d) begin
                            state_q    <= S_LATCH;
                            ready_q    <= 1'b0;
                            ready_oe_q <= 1'b1;
                        end
                    end
                end
                S_LATCH: begin
                    if (strobe) begin
                        cyc_wr_q <= ~wr_ & ~inta_q;
                        rd_q     <= wr_ & ~inta_q;
                        wr_q     <= ~wr_ & ~inta_q;
                        if (!wr_)
                            wdata_q <= ad_i;
                        if (inta_q)
                            ad_q <= INTA_OPC;
                        state_q <= S_REQ;
                    end else if (ale) begin
                        // Bus idle cycle (e.g. DAD): a fresh ALE replaces the
                        // decode; a miss releases READY.
                        addr_q <= addr_d;
                        io_q   <= io_type_d;
                        inta_q <= inta_hit_d;
                        if (!hit_d) begin
                            state_q    <= S_IDLE;
                            ready_q    <= 1'b1;
                            ready_oe_q <= 1'b0;
                        end
                    end
                end
                S_REQ: begin
                    if (!strobe) begin
                        state_q    <= S_IDLE;
                        ready_q    <= 1'b1;
                        ready_oe_q <= 1'b0;
                    end else begin
                        wcnt_q  <= 4'(WAITS);
                        tcnt_q  <= 8'(TIMEOUT);
                        acked_q <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!strobe) begin
                        // Strobe released early: abandon the request.
                        state_q    <= S_IDLE;
                        ready_q    <= 1'b1;
                        ready_oe_q <= 1'b0;
                    end else begin
                        if (loc_ack) begin
                            acked_q <= 1'b1;
                            if (!cyc_wr_q && !inta_q)
                                ad_q <= loc_rdata;
                        end
                        wcnt_q <= (wcnt_q != 4'd0) ? wcnt_q - 4'd1 : 4'd0;
                        tcnt_q <= (tcnt_q != 8'd0) ? tcnt_q - 8'd1 : 8'd0;
                        if (ack_now && wcnt_q == 4'd0) begin
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                        end else if (!ack_now && tcnt_q <= 8'd1) begin
                            // Timeout counter reaches 0 this cycle; an ack in
                            // the same cycle is handled by the branch above.
                            state_q <= S_DONE;
                            ready_q <= 1'b1;
                            ad_q    <= 8'hFF;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (rd_ && wr_ && inta_) begin
                        state_q    <= S_IDLE;
                        ready_oe_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Drive AD only while the CPU read/INTA strobe is low, so release follows
    // the strobe combinationally.
    assign ad_oe = ((state_q == S_WAIT) || (state_q == S_DONE)) && !cyc_wr_q &&
                   (!rd_ || !inta_);

    assign ad_o      = ad_q;
    assign ready     = ready_q;
    assign ready_oe  = ready_oe_q;
    assign loc_addr  = addr_q;
    assign loc_io    = io_q;
    assign loc_rd    = rd_q;
    assign loc_wr    = wr_q;
    assign loc_wdata = wdata_q;
    assign err       = err_q;

endmodule
